// File: rtl/uart_tx_arb_pkg.sv
// Shared types and default sizing for the UART TX arbiter.
// Imported by the arbiter top and its round-robin picker.
package uart_tx_arb_pkg;

  localparam int NUM_REQ_DEF      = 4;
  localparam int DATA_WIDTH_DEF   = 8;
  localparam int BUSY_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or above
// i_ptr, wrapping around, as a one-hot vector and as an index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  int w_pos;

  // Scan from farthest to nearest so the nearest hit is written last.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = (int'(i_ptr) + k) % NUM_REQ;
      if (i_req[w_pos]) begin
        o_grant        = '0;
        o_grant[w_pos] = 1'b1;
        o_idx          = IW'(w_pos);
        o_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter: grant, launch,
// follow tx_busy to frame end, flag a transmitter that never starts.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            cfg_par_en,
  input  logic [NUM_REQ-1:0]            cfg_par_type,
  input  logic                          arb_en,
  input  logic                          err_clr,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_data_valid,
  output logic                          tx_par_en,
  output logic                          tx_par_type,
  input  logic                          tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          frame_done,
  output logic                          err_timeout
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT);

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic [IW-1:0]        r_ptr;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_inc;
  logic [NUM_REQ-1:0]   w_grant_oh;
  logic [IW-1:0]        w_idx;
  logic [IW-1:0]        w_ptr_nxt;
  logic                 w_any;
  logic                 w_take;
  logic                 w_done;
  logic                 w_tout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant_oh),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_ptr_nxt = (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
  assign req_ready = (w_take && !RST) ? w_grant_oh : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_done      = 1'b0;
    w_tout      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (arb_en && !tx_busy && w_any) begin
          w_take      = 1'b1;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: w_state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_nxt = WAIT_DONE;
        end else if (w_cnt_inc == CW'(BUSY_TIMEOUT - 1)) begin
          w_tout      = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      tx_par_en     <= 1'b0;
      tx_par_type   <= 1'b0;
      grant_id      <= '0;
      frame_done    <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      tx_data_valid <= w_take;
      frame_done    <= w_done;
      if (w_take) begin
        tx_data     <= req_data[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
        tx_par_en   <= cfg_par_en[w_idx];
        tx_par_type <= cfg_par_type[w_idx];
        grant_id    <= w_idx;
        r_ptr       <= w_ptr_nxt;
      end
      if (r_state == LAUNCH)
        r_cnt <= '0;
      else if (r_state == WAIT_BUSY && !tx_busy && !w_tout)
        r_cnt <= w_cnt_inc;
      // A timeout in the same cycle as a clear must stay visible.
      if (w_tout)
        err_timeout <= 1'b1;
      else if (err_clr)
        err_timeout <= 1'b0;
    end
  end

endmodule
